alu_result_display: RTL

- Output-side counterpart to the switch/button operand-entry path. It takes an ALU result plus its ZERO and CARRY flags and presents them on a 4-digit, common-anode 7-segment display in hex or decimal.
- Decimal uses a sequential binary-to-BCD (shift-add-3) engine.
- A time-multiplexed scanner drives the display.
- Sits between the ALU outputs and the board display pins in the top-level test designs.

---
 rtl/alu_result_display_pkg.sv | 56 +++++
 rtl/alu_result_display_bin_to_bcd.sv | 52 +++++
 rtl/alu_result_display.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: segment codes (active-low, g..a),
// conversion length and the capture FSM encoding.
package alu_result_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_C     = 7'h46;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // One shift-add-3 iteration per input bit.
  localparam int BCD_ITERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [6:0] nib_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_result_display_bin_to_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per cycle.
// start_i loads the operand; last_o is high during the cycle whose edge performs the final iteration.
module bin_to_bcd_seq
  import alu_result_display_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        last_o,
  output logic [11:0] bcd_o
);

  localparam logic [2:0] LAST_CNT = 3'(BCD_ITERS - 1);

  logic        running_q;
  logic [2:0]  cnt_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] adj;
  logic [19:0] shifted;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running_q <= 1'b0;
      cnt_q     <= 3'd0;
      bin_q     <= 8'd0;
      bcd_q     <= 12'd0;
    end else if (start_i) begin
      running_q <= 1'b1;
      cnt_q     <= 3'd0;
      bin_q     <= bin_i;
      bcd_q     <= 12'd0;
    end else if (running_q) begin
      {bcd_q, bin_q} <= shifted;
      cnt_q          <= cnt_q + 3'd1;
      if (cnt_q == LAST_CNT) running_q <= 1'b0;
    end
  end

  assign last_o = running_q && (cnt_q == LAST_CNT);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/alu_result_display.sv
// ALU result + ZERO/CARRY flags on a 4-digit common-anode 7-segment display, hex or decimal.
// Capture FSM feeds a shadow register; shown registers update atomically in COMMIT.
module alu_result_display
  import alu_result_display_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] VALUE,
  input  logic       ZERO_IN,
  input  logic       CARRY_IN,
  input  logic       MODE_DEC,
  input  logic       LOAD,
  output logic       BUSY,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int             CW      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIGIT_TICKS - 1);

  state_e      state_q, state_d;
  logic        capture;
  logic        conv_start;
  logic        conv_last;
  logic [11:0] conv_bcd;

  logic [7:0]  sh_value_q;
  logic        sh_zero_q, sh_carry_q, sh_dec_q;

  logic [3:0]  dig0_q, dig1_q, dig2_q, dig0_d, dig1_d, dig2_d;
  logic        show_dec_q, show_zero_q, show_carry_q;
  logic        show_dec_d, show_zero_d, show_carry_d;

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          capture = 1'b1;
          state_d = MODE_DEC ? ST_CONV : ST_COMMIT;
        end
      end
      ST_CONV:   if (conv_last) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign conv_start = capture & MODE_DEC;
  assign BUSY       = (state_q != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      sh_value_q <= 8'd0;
      sh_zero_q  <= 1'b0;
      sh_carry_q <= 1'b0;
      sh_dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        sh_value_q <= VALUE;
        sh_zero_q  <= ZERO_IN;
        sh_carry_q <= CARRY_IN;
        sh_dec_q   <= MODE_DEC;
      end
    end
  end

  // The converter takes VALUE directly on the capture edge so all 8 CONV cycles iterate.
  bin_to_bcd_seq u_bin_to_bcd (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .start_i (conv_start),
    .bin_i   (VALUE),
    .last_o  (conv_last),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    dig0_d       = dig0_q;
    dig1_d       = dig1_q;
    dig2_d       = dig2_q;
    show_dec_d   = show_dec_q;
    show_zero_d  = show_zero_q;
    show_carry_d = show_carry_q;
    if (state_q == ST_COMMIT) begin
      if (sh_dec_q) begin
        dig0_d = conv_bcd[3:0];
        dig1_d = conv_bcd[7:4];
        dig2_d = conv_bcd[11:8];
      end else begin
        dig0_d = sh_value_q[3:0];
        dig1_d = sh_value_q[7:4];
        dig2_d = 4'd0;
      end
      show_dec_d   = sh_dec_q;
      show_zero_d  = sh_zero_q;
      show_carry_d = sh_carry_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dig0_q       <= 4'd0;
      dig1_q       <= 4'd0;
      dig2_q       <= 4'd0;
      show_dec_q   <= 1'b0;
      show_zero_q  <= 1'b0;
      show_carry_q <= 1'b0;
    end else begin
      dig0_q       <= dig0_d;
      dig1_q       <= dig1_d;
      dig2_q       <= dig2_d;
      show_dec_q   <= show_dec_d;
      show_zero_q  <= show_zero_d;
      show_carry_q <= show_carry_d;
    end
  end

  // Segments use the next shown state so a COMMIT appears on the display at the same edge.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    case (idx_q)
      2'd0: seg_d = nib_to_seg(dig0_d);
      2'd1: seg_d = (show_dec_d && dig2_d == 4'd0 && dig1_d == 4'd0) ? SEG_BLANK
                                                                      : nib_to_seg(dig1_d);
      2'd2: seg_d = (!show_dec_d || dig2_d == 4'd0) ? SEG_BLANK : nib_to_seg(dig2_d);
      default: begin
        seg_d = show_carry_d ? SEG_C : SEG_BLANK;
        dp_d  = ~show_zero_d;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule
